// File: rtl/inst_prefetch_queue_if.sv
// Bundle of the redirect, instruction-memory and decode-side signals of the prefetch queue.
// The queue uses the master modport; memory, branch control and decode sit on the slave side.
interface inst_prefetch_queue_if #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_rvalid;
   logic [XLEN-1:0] imem_rdata;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [XLEN-1:0] out_instr;
   logic [LW-1:0]   level;
   logic [1:0]      fsm_state;

   modport master (
      input  redirect_valid, redirect_pc, imem_rvalid, imem_rdata, out_ready,
      output imem_req, imem_addr, out_valid, out_pc, out_instr, level, fsm_state
   );

   modport slave (
      output redirect_valid, redirect_pc, imem_rvalid, imem_rdata, out_ready,
      input  imem_req, imem_addr, out_valid, out_pc, out_instr, level, fsm_state
   );
endinterface

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: sequential fetch into a DEPTH-entry {pc, instr} FIFO, flushed on redirect.
// Optional build macro IPQ_PERF_CNT_EN adds flush_cnt and starve_cnt saturating counters.
module inst_prefetch_queue #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                   clk,
   input  logic                   rstn,
   inst_prefetch_queue_if.master  bus
`ifdef IPQ_PERF_CNT_EN
   ,
   output logic [31:0]            flush_cnt,
   output logic [31:0]            starve_cnt
`endif
);

   // Handshakes: a transfer happens on a clock edge where valid and ready are both 1.
   // imem: imem_req/imem_addr hold until imem_rvalid; out: out_valid means count != 0,
   // out_ready is the inverse of decode stall. redirect_valid voids same-cycle transfers.

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DROP = 2'd2
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] fetch_pc_next;
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic [CW-1:0]   count;
   logic [CW-1:0]   count_next;
   logic            push;
   logic            pop;

   logic [XLEN-1:0] pc_mem    [DEPTH];
   logic [XLEN-1:0] instr_mem [DEPTH];

   logic unused_pc_bits;
   assign unused_pc_bits = &bus.redirect_pc[1:0];

   always_comb begin
      push       = (state == REQ) && bus.imem_rvalid && !bus.redirect_valid;
      pop        = (count != '0) && bus.out_ready && !bus.redirect_valid;
      count_next = count;
      if (push && !pop) begin
         count_next = count + 1'b1;
      end else if (!push && pop) begin
         count_next = count - 1'b1;
      end
   end

   always_comb begin
      state_next    = state;
      fetch_pc_next = fetch_pc;
      case (state)
         IDLE: begin
            if (bus.redirect_valid || (count < DEPTH_C)) begin
               state_next = REQ;
            end
         end
         REQ: begin
            if (bus.redirect_valid) begin
               // A request still in flight must have its response swallowed before refetching.
               state_next = bus.imem_rvalid ? REQ : DROP;
            end else if (bus.imem_rvalid) begin
               state_next = (count_next < DEPTH_C) ? REQ : IDLE;
            end
         end
         DROP: begin
            // A redirect here only retargets fetch_pc; the orphan still has to drain.
            if (bus.imem_rvalid) begin
               state_next = REQ;
            end
         end
         default: state_next = IDLE;
      endcase
      if (bus.redirect_valid) begin
         fetch_pc_next = {bus.redirect_pc[XLEN-1:2], 2'b00};
      end else if (push) begin
         fetch_pc_next = fetch_pc + XLEN'(4);
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         state    <= state_next;
         fetch_pc <= fetch_pc_next;
         if (bus.redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            count <= count_next;
            if (push) begin
               wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
               rd_ptr <= rd_ptr + 1'b1;
            end
         end
      end
   end

   // Storage needs no reset: count gates visibility of every entry.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]    <= fetch_pc;
         instr_mem[wr_ptr] <= bus.imem_rdata;
      end
   end

   assign bus.imem_req  = (state == REQ);
   assign bus.imem_addr = fetch_pc;
   assign bus.out_valid = (count != '0);
   assign bus.out_pc    = pc_mem[rd_ptr];
   assign bus.out_instr = instr_mem[rd_ptr];
   assign bus.level     = count;
   assign bus.fsm_state = state;

`ifdef IPQ_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (!rstn) begin
         flush_cnt  <= '0;
         starve_cnt <= '0;
      end else begin
         if (bus.redirect_valid && (flush_cnt != 32'hFFFF_FFFF)) begin
            flush_cnt <= flush_cnt + 32'd1;
         end
         if ((count == '0) && bus.out_ready && (starve_cnt != 32'hFFFF_FFFF)) begin
            starve_cnt <= starve_cnt + 32'd1;
         end
      end
   end
`else
   // Default build carries no performance counters.
`endif

endmodule
